// File: rtl/swin_conf_pkg.sv
// Constants shared by the configuration loader and decoder, plus the loader state encoding.
package swin_conf_pkg;

  localparam int CONF_DATA_WIDTH = 15;
  localparam int CONF_ADDR_WIDTH = 9;
  localparam int RAMB36_WIDTH    = 72;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE,
    ST_RUN
  } loader_state_e;

endpackage

// File: rtl/conf_loader_if.sv
// Host-to-loader configuration entry stream (valid/ready with end-of-table marker).
interface conf_loader_if
  import swin_conf_pkg::*;
;
  logic [CONF_DATA_WIDTH-1:0] conf_in_data;
  logic                       conf_in_vld;
  logic                       conf_in_last;
  logic                       conf_in_rdy;

  modport master (
    output conf_in_data,
    output conf_in_vld,
    output conf_in_last,
    input  conf_in_rdy
  );

  modport slave (
    input  conf_in_data,
    input  conf_in_vld,
    input  conf_in_last,
    output conf_in_rdy
  );
endinterface

// File: rtl/conf_loader.sv
// Loads a host configuration table into the config BRAM, one entry per address,
// then reports the entry count and enables the decoder; overflowing tables are drained and dropped.
module conf_loader
  import swin_conf_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       conf_start,
  conf_loader_if.slave               conf_in,
  output logic                       conf_bram_wr_en,
  output logic [CONF_ADDR_WIDTH-1:0] conf_bram_wr_addr,
  output logic [RAMB36_WIDTH-1:0]    conf_bram_wr_data,
  output logic [CONF_ADDR_WIDTH:0]   conf_len,
  output logic                       load_done,
  output logic                       conf_err,
  output logic                       decoder_en
);

  localparam int PAD_W = RAMB36_WIDTH - CONF_DATA_WIDTH;
  localparam logic [CONF_ADDR_WIDTH:0] PTR_LAST = {1'b0, {CONF_ADDR_WIDTH{1'b1}}};

  loader_state_e               state_q, state_d;
  logic [CONF_ADDR_WIDTH:0]    wr_ptr_q, wr_ptr_d;
  logic                        rdy_q, rdy_d;
  logic                        wr_en_q, wr_en_d;
  logic [CONF_ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [RAMB36_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic [CONF_ADDR_WIDTH:0]    len_q, len_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;
  logic                        den_q, den_d;
  logic                        accept;

  assign accept = conf_in.conf_in_vld && rdy_q;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rdy_d     = rdy_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    len_d     = len_q;
    done_d    = 1'b0;
    err_d     = err_q;
    den_d     = den_q;

    unique case (state_q)
      // Dropping decoder_en on the start edge keeps the decoder off before any overwrite.
      ST_IDLE, ST_RUN: begin
        if (conf_start) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
          err_d    = 1'b0;
          den_d    = 1'b0;
          rdy_d    = 1'b1;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_ptr_q[CONF_ADDR_WIDTH-1:0];
          wr_data_d = {{PAD_W{1'b0}}, conf_in.conf_in_data};
          wr_ptr_d  = wr_ptr_q + (CONF_ADDR_WIDTH+1)'(1);
          if (conf_in.conf_in_last) begin
            state_d = ST_DONE;
            rdy_d   = 1'b0;
          end else if (wr_ptr_q == PTR_LAST) begin
            state_d = ST_DRAIN;
            err_d   = 1'b1;
          end
        end
      end
      // Swallow the rest of an oversized table so the host can finish its stream.
      ST_DRAIN: begin
        if (accept && conf_in.conf_in_last) begin
          state_d = ST_IDLE;
          rdy_d   = 1'b0;
        end
      end
      ST_DONE: begin
        len_d   = wr_ptr_q;
        done_d  = 1'b1;
        den_d   = 1'b1;
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
        rdy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rdy_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      len_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      den_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rdy_q     <= rdy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      len_q     <= len_d;
      done_q    <= done_d;
      err_q     <= err_d;
      den_q     <= den_d;
    end
  end

  assign conf_in.conf_in_rdy = rdy_q;
  assign conf_bram_wr_en     = wr_en_q;
  assign conf_bram_wr_addr   = wr_addr_q;
  assign conf_bram_wr_data   = wr_data_q;
  assign conf_len            = len_q;
  assign load_done           = done_q;
  assign conf_err            = err_q;
  assign decoder_en          = den_q;

endmodule
